// File: rtl/uart_rx.sv
// uart_rx - 8N1 serial receiver with valid/ready byte handoff and sticky framing/overrun flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             rx_s;
  logic             deliver;

  assign rx_s   = sync_q[1];
  assign sync_d = {sync_q[0], rx};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    deliver = 1'b0;

    // Clear first so a same-cycle set below takes priority.
    if (err_clr) begin
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A consumer accept on the delivery edge frees the slot for the new byte.
    if (deliver) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int C   = 16;
  localparam int H   = C / 2;
  localparam int LAT = 2 + H + 9 * C + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_ready (rx_ready),
    .err_clr  (err_clr),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   fe_rises = 0;
  logic fe_prev = 1'b0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    fe_prev <= frame_err;
    if (frame_err && !fe_prev) fe_rises <= fe_rises + 1;
  end

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit push);
    if (push) exp_q.push_back(b);
    rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int t0, output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 12 * C && !got; i++) begin
      @(negedge clk);
      if (rx_valid) begin
        lat = cyc - t0;
        got = 1'b1;
      end
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(rx_data), 32'(e));
    end
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    int t0, lat;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Basic reception, latency, hold and accept.
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      wait_valid(t0, lat);
    join
    chk("lat_a5", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);
    pop_chk("data_a5");
    repeat (20) @(posedge clk);
    #1;
    chk("hold_valid", 32'(rx_valid), 32'd1);
    accept();
    chk("acc_valid", 32'(rx_valid), 32'd0);
    chk("acc_data", 32'(rx_data), 32'hA5);

    // Short low glitch is rejected at mid start bit.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    repeat (C) @(posedge clk);
    #1;
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    chk("glitch_valid", 32'(rx_valid), 32'd0);
    chk("glitch_ferr", 32'(frame_err), 32'd0);

    // Bad stop bit followed by a long break.
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40 * C) @(posedge clk);
    #1;
    chk("brk_ferr", 32'(frame_err), 32'd1);
    chk("brk_once", 32'(fe_rises), 32'd1);
    chk("brk_valid", 32'(rx_valid), 32'd0);
    chk("brk_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("brk_idle", 32'(busy), 32'd0);
    pulse_clr();
    chk("brk_clr", 32'(frame_err), 32'd0);
    t0 = cyc;
    fork
      send_frame(8'h81, 1'b1, 1'b1);
      wait_valid(t0, lat);
    join
    chk("lat_81", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);
    pop_chk("data_81");
    chk("ferr_81", 32'(frame_err), 32'd0);
    accept();

    // Back-to-back with no consumer: second byte overruns.
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    pop_chk("ovr_data");
    chk("ovr_set", 32'(overrun), 32'd1);
    pulse_clr();
    chk("ovr_clr", 32'(overrun), 32'd0);
    chk("ovr_keep", 32'(rx_data), 32'h11);

    // Accept landing exactly on the stop-sample edge lets the new byte in.
    fork
      send_frame(8'h22, 1'b1, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    pop_chk("stop_acc_data");
    chk("stop_acc_valid", 32'(rx_valid), 32'd1);
    chk("stop_acc_ovr", 32'(overrun), 32'd0);
    accept();

    // Reset in the middle of a frame.
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        repeat (5 * C + H) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_data", 32'(rx_data), 32'd0);
        chk("mid_valid", 32'(rx_valid), 32'd0);
        chk("mid_ferr", 32'(frame_err), 32'd0);
        chk("mid_ovr", 32'(overrun), 32'd0);
        chk("mid_busy0", 32'(busy), 32'd0);
      end
    join
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    t0 = cyc;
    fork
      send_frame(8'h5A, 1'b1, 1'b1);
      wait_valid(t0, lat);
    join
    chk("lat_5a", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);
    pop_chk("data_5a");
    chk("ferr_5a", 32'(frame_err), 32'd0);
    chk("ovr_5a", 32'(overrun), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
